freelist: RTL and testbench

Physical-register free list feeding the rename stage. Holds every physical register number not mapped by the architectural RAT in a circular buffer. Supplies up to two free destination pregs per cycle to rename and accepts up to two released old pregs per cycle from commit. Recovers speculative allocations on flush by rewinding the allocation pointer to a commit-maintained architectural head.

---
 rtl/freelist_if.sv | 53 +++++
 rtl/freelist.sv | 148 ++++++++++++++
 tb/tb_freelist.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/freelist_if.sv
// Rename/commit/flush bundle between the pipeline and the physical-register
// free list. The master side is the pipeline (rename + commit + flush); the
// slave side is the free list itself.
interface freelist_if #(
  parameter int PREG_NUM = 64,
  parameter int LREG_NUM = 32
);
  localparam int PREG_W = $clog2(PREG_NUM);
  localparam int DEPTH  = PREG_NUM - LREG_NUM;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  // rename request / offer
  logic              rn2fl_instr0_lrd_valid;
  logic              rn2fl_instr1_lrd_valid;
  logic [PREG_W-1:0] fl2rn_instr0prd;
  logic [PREG_W-1:0] fl2rn_instr1prd;
  logic              fl2rn_instr0_ok;
  logic              fl2rn_instr1_ok;

  // commit release
  logic              commit0_valid;
  logic              commit1_valid;
  logic              commit0_need_to_wb;
  logic              commit1_need_to_wb;
  logic [PREG_W-1:0] commit0_old_prd;
  logic [PREG_W-1:0] commit1_old_prd;

  // recovery and status
  logic              flush_valid;
  logic [CNT_W-1:0]  fl_free_count;

  modport master (
    output rn2fl_instr0_lrd_valid, rn2fl_instr1_lrd_valid,
    output commit0_valid, commit1_valid,
    output commit0_need_to_wb, commit1_need_to_wb,
    output commit0_old_prd, commit1_old_prd,
    output flush_valid,
    input  fl2rn_instr0prd, fl2rn_instr1prd,
    input  fl2rn_instr0_ok, fl2rn_instr1_ok,
    input  fl_free_count
  );

  modport slave (
    input  rn2fl_instr0_lrd_valid, rn2fl_instr1_lrd_valid,
    input  commit0_valid, commit1_valid,
    input  commit0_need_to_wb, commit1_need_to_wb,
    input  commit0_old_prd, commit1_old_prd,
    input  flush_valid,
    output fl2rn_instr0prd, fl2rn_instr1prd,
    output fl2rn_instr0_ok, fl2rn_instr1_ok,
    output fl_free_count
  );
endinterface

// File: rtl/freelist.sv
// Physical-register free list for the rename stage.
// Circular buffer of the pregs not held by the architectural RAT. Rename pops
// up to two pregs per cycle at head (zero latency), commit pushes up to two
// old mappings per cycle at tail. arch_head tracks head as seen by committed
// instructions, so a flush simply rewinds head to it. All pointers carry an
// extra wrap bit so that full (count == DEPTH) and empty are distinct.
module freelist #(
  parameter int PREG_NUM = 64,
  parameter int LREG_NUM = 32
) (
  input  logic      clock,
  input  logic      reset,
  freelist_if.slave fl
);
  localparam int DEPTH  = PREG_NUM - LREG_NUM;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int PREG_W = $clog2(PREG_NUM);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  // storage and pointers
  logic [PREG_W-1:0] entry_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  arch_head_r;
  logic [PTR_W-1:0]  tail_r;

  // derived state
  logic [PTR_W-1:0]  head_p1_s;
  logic [CNT_W-1:0]  count_s;
  logic              ok0_s;
  logic              ok1_s;

  // allocation / release decode
  logic              grant0_s;
  logic              grant1_s;
  logic              rel0_s;
  logic              rel1_s;
  logic [PTR_W-1:0]  alloc_n_s;
  logic [PTR_W-1:0]  rel_n_s;

  // entry write ports
  logic              wr0_en_s;
  logic              wr1_en_s;
  logic [IDX_W-1:0]  wr0_idx_s;
  logic [IDX_W-1:0]  wr1_idx_s;
  logic [PREG_W-1:0] wr0_data_s;
  logic [PREG_W-1:0] wr1_data_s;

  // next pointers
  logic [PTR_W-1:0]  head_nxt_s;
  logic [PTR_W-1:0]  arch_head_nxt_s;
  logic [PTR_W-1:0]  tail_nxt_s;

  // Free count and availability flags; only instr1_ok sees a live input
  // (instr0's request) so instr1 can be refused when a single entry is left.
  always_comb begin
    head_p1_s = head_r + {{(PTR_W-1){1'b0}}, 1'b1};
    // wrap-bit pointers make this subtraction exact for 0..DEPTH
    count_s   = CNT_W'(tail_r - head_r);
    ok0_s     = (count_s != {CNT_W{1'b0}});
    if (fl.rn2fl_instr0_lrd_valid) begin
      ok1_s = (count_s >= CNT_W'(2));
    end else begin
      ok1_s = ok0_s;
    end
  end

  // Offer muxes: instr1 takes the second entry only when instr0 consumes one.
  always_comb begin
    fl.fl2rn_instr0prd = entry_r[head_r[IDX_W-1:0]];
    if (fl.rn2fl_instr0_lrd_valid) begin
      fl.fl2rn_instr1prd = entry_r[head_p1_s[IDX_W-1:0]];
    end else begin
      fl.fl2rn_instr1prd = entry_r[head_r[IDX_W-1:0]];
    end
    fl.fl2rn_instr0_ok = ok0_s;
    fl.fl2rn_instr1_ok = ok1_s;
    fl.fl_free_count   = count_s;
  end

  // Grant decode: requests without their ok are dropped, and nothing is
  // granted in a flush cycle because those allocations are being squashed.
  always_comb begin
    grant0_s  = fl.rn2fl_instr0_lrd_valid & ok0_s & ~fl.flush_valid;
    grant1_s  = fl.rn2fl_instr1_lrd_valid & ok1_s & ~fl.flush_valid;
    alloc_n_s = PTR_W'(grant0_s) + PTR_W'(grant1_s);
    rel0_s    = fl.commit0_valid & fl.commit0_need_to_wb;
    rel1_s    = fl.commit1_valid & fl.commit1_need_to_wb;
    rel_n_s   = PTR_W'(rel0_s) + PTR_W'(rel1_s);
  end

  // Release write ports: slot 0 lands at tail, slot 1 right behind it, or at
  // tail itself when slot 0 is not releasing, so the two never collide.
  always_comb begin
    wr0_en_s   = rel0_s;
    wr0_idx_s  = tail_r[IDX_W-1:0];
    wr0_data_s = fl.commit0_old_prd;
    wr1_en_s   = rel1_s;
    wr1_data_s = fl.commit1_old_prd;
    if (rel0_s) begin
      wr1_idx_s = tail_r[IDX_W-1:0] + {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      wr1_idx_s = tail_r[IDX_W-1:0];
    end
  end

  // Pointer next-state: a flush rewinds head to the committed head including
  // this cycle's releases, which keeps the count at exactly DEPTH afterwards.
  always_comb begin
    tail_nxt_s      = tail_r + rel_n_s;
    arch_head_nxt_s = arch_head_r + rel_n_s;
    if (fl.flush_valid) begin
      head_nxt_s = arch_head_r + rel_n_s;
    end else begin
      head_nxt_s = head_r + alloc_n_s;
    end
  end

  // Pointer registers; reset leaves the list full with head and tail one lap apart.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r      <= {PTR_W{1'b0}};
      arch_head_r <= {PTR_W{1'b0}};
      tail_r      <= {1'b1, {IDX_W{1'b0}}};
    end else begin
      head_r      <= head_nxt_s;
      arch_head_r <= arch_head_nxt_s;
      tail_r      <= tail_nxt_s;
    end
  end

  // Entry storage; reset loads the pregs not used by the initial RAT mapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= PREG_W'(LREG_NUM + i);
      end
    end else begin
      if (wr0_en_s) begin
        entry_r[wr0_idx_s] <= wr0_data_s;
      end
      if (wr1_en_s) begin
        entry_r[wr1_idx_s] <= wr1_data_s;
      end
    end
  end

endmodule

// File: tb/tb_freelist.sv
// Directed scoreboard bench for the free list: each step drives the inputs,
// pushes the outputs it expects for that cycle, then pops and compares them.
module tb_freelist;
  localparam int PREG_NUM = 64;
  localparam int LREG_NUM = 32;

  // selectors for the observed output
  localparam int S_CNT = 0;
  localparam int S_P0  = 1;
  localparam int S_P1  = 2;
  localparam int S_OK0 = 3;
  localparam int S_OK1 = 4;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  logic clock;
  logic reset;
  exp_t sb_q[$];
  int   n_pass;
  int   n_total;

  freelist_if #(.PREG_NUM(PREG_NUM), .LREG_NUM(LREG_NUM)) fl_if ();

  freelist #(.PREG_NUM(PREG_NUM), .LREG_NUM(LREG_NUM)) dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] observe(input int sel);
    logic [31:0] v;
    v = 32'hDEAD_BEEF;
    case (sel)
      S_CNT:   v = {26'd0, fl_if.fl_free_count};
      S_P0:    v = {26'd0, fl_if.fl2rn_instr0prd};
      S_P1:    v = {26'd0, fl_if.fl2rn_instr1prd};
      S_OK0:   v = {31'd0, fl_if.fl2rn_instr0_ok};
      S_OK1:   v = {31'd0, fl_if.fl2rn_instr1_ok};
      default: v = 32'hDEAD_BEEF;
    endcase
    return v;
  endfunction

  task automatic push(input int sel, input int exp, input string tag);
    exp_t e;
    e.sel = sel;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // let combinational outputs settle, then compare everything queued
  task automatic settle_check();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.sel);
      n_total = n_total + 1;
      assert (obs === e.exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
    end
  endtask

  task automatic drive(input logic v0, input logic v1,
                       input logic r0, input int o0,
                       input logic r1, input int o1,
                       input logic fl);
    fl_if.rn2fl_instr0_lrd_valid = v0;
    fl_if.rn2fl_instr1_lrd_valid = v1;
    fl_if.commit0_valid          = r0;
    fl_if.commit0_need_to_wb     = r0;
    fl_if.commit0_old_prd        = 6'(o0);
    fl_if.commit1_valid          = r1;
    fl_if.commit1_need_to_wb     = r1;
    fl_if.commit1_old_prd        = 6'(o1);
    fl_if.flush_valid            = fl;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // reset state, idle
    push(S_CNT, 32, "rst_count"); push(S_P0, 32, "rst_p0"); push(S_P1, 32, "rst_p1");
    push(S_OK0, 1, "rst_ok0");    push(S_OK1, 1, "rst_ok1");
    settle_check();

    // dual alloc for two cycles
    @(negedge clock); drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_P0, 32, "dual1_p0"); push(S_P1, 33, "dual1_p1"); push(S_CNT, 32, "dual1_cnt");
    settle_check();
    @(negedge clock); drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_P0, 34, "dual2_p0"); push(S_P1, 35, "dual2_p1"); push(S_CNT, 30, "dual2_cnt");
    settle_check();
    @(negedge clock); drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_CNT, 28, "dual_after_cnt"); push(S_P0, 36, "dual_after_p0");
    settle_check();

    // instr1-only allocation takes entry[head]
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_P1, 32, "i1only_p1"); push(S_OK1, 1, "i1only_ok1");
    settle_check();
    @(negedge clock); drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_CNT, 31, "i1only_cnt"); push(S_P0, 33, "i1only_p0");
    settle_check();

    // drain the whole list with 16 dual allocations
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      push(S_P0, 32 + 2 * k, "drain_p0");
      push(S_P1, 33 + 2 * k, "drain_p1");
      settle_check();
      @(negedge clock);
    end
    // empty: extra request is refused and must not move head
    drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_CNT, 0, "empty_cnt"); push(S_OK0, 0, "empty_ok0"); push(S_OK1, 0, "empty_ok1");
    settle_check();
    @(negedge clock); drive(1'b0, 1'b0, 1'b1, 5, 1'b0, 0, 1'b0);
    push(S_CNT, 0, "empty_hold_cnt"); push(S_P0, 32, "empty_hold_p0");
    settle_check();
    @(negedge clock); drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_CNT, 1, "rel5_cnt"); push(S_P0, 5, "rel5_p0");
    push(S_OK0, 1, "rel5_ok0"); push(S_OK1, 1, "rel5_ok1");
    settle_check();
    // single entry: instr1 refused when instr0 also asks
    @(negedge clock); drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_OK0, 1, "one_ok0"); push(S_OK1, 0, "one_ok1"); push(S_P0, 5, "one_p0");
    settle_check();
    @(negedge clock); drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_CNT, 0, "one_after_cnt"); push(S_OK0, 0, "one_after_ok0");
    settle_check();

    // wrap: head to 30, alloc 1 with a simultaneous dual release at tail 0/1
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      @(negedge clock);
    end
    drive(1'b1, 1'b0, 1'b1, 10, 1'b1, 11, 1'b0);
    push(S_CNT, 2, "wrap_pre_cnt"); push(S_P0, 62, "wrap_pre_p0");
    settle_check();
    @(negedge clock); drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_CNT, 3, "wrap_cnt"); push(S_P0, 63, "wrap_p0"); push(S_P1, 10, "wrap_p1");
    push(S_OK1, 1, "wrap_ok1");
    settle_check();
    @(negedge clock); drive(1'b0, 1'b0, 1'b0, 0, 1'b1, 12, 1'b0);
    push(S_CNT, 1, "wrap_after_cnt"); push(S_P0, 11, "wrap_after_p0");
    settle_check();
    // slot-1-only release lands at tail
    @(negedge clock); drive(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_CNT, 2, "slot1_cnt"); push(S_P0, 11, "slot1_p0"); push(S_P1, 12, "slot1_p1");
    settle_check();

    // alloc 6, commit two, flush next cycle (flush-cycle requests ignored)
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
      @(negedge clock);
    end
    drive(1'b0, 1'b0, 1'b1, 3, 1'b1, 7, 1'b0);
    push(S_CNT, 26, "flush_pre_cnt");
    settle_check();
    @(negedge clock); drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);
    push(S_CNT, 28, "flush_cyc_cnt");
    settle_check();
    @(negedge clock); drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_CNT, 32, "flush_cnt"); push(S_P0, 34, "flush_p0"); push(S_P1, 35, "flush_p1");
    settle_check();
    @(negedge clock); drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_CNT, 30, "flush_a2_cnt"); push(S_P0, 36, "flush_a2_p0");
    settle_check();
    // flush together with one release: head = arch_head + 1
    @(negedge clock); drive(1'b1, 1'b0, 1'b1, 9, 1'b0, 0, 1'b1);
    push(S_CNT, 28, "flrel_cyc_cnt");
    settle_check();
    @(negedge clock); drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_CNT, 32, "flrel_cnt"); push(S_P0, 35, "flrel_p0");
    settle_check();

    // reset overrides alloc, release and flush in the same cycle
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 20, 1'b1, 21, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    push(S_CNT, 32, "rst_ovr_cnt"); push(S_P0, 32, "rst_ovr_p0"); push(S_P1, 32, "rst_ovr_p1");
    settle_check();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
